// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: AHB3-Lite encodings, slave FSM states and the byte-lane enable helper
// shared by the SRAM slave and its storage array.
package ahb3lite_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    // Lane mask for a transfer of 2**size bytes starting at byte offset within the bus word.
    function automatic logic [7:0] byte_enable(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] lanes;
        lanes = (size == 2'd3) ? 8'hFF : (size == 2'd2) ? 8'h0F : (size == 2'd1) ? 8'h03 : 8'h01;
        return lanes << offset;
    endfunction
endpackage

// File: rtl/ahb3lite_sram_ws_sram_1rw_be.sv
// sram_1rw_be: single-port DEPTH x WIDTH array with per-byte write enables,
// synchronous write and combinational read at the same address.
module sram_1rw_be #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [WIDTH/8-1:0] be,
    input  logic [AW-1:0]      addr,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < WIDTH / 8; i++)
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];

    assign rdata = mem[addr];
endmodule

// File: rtl/ahb3lite_sram_ws.sv
// ahb3lite_sram_ws: AHB3-Lite SRAM slave with programmable wait states, a two-cycle ERROR
// response for illegal accesses, byte-lane writes and same-word write-to-read forwarding.
module ahb3lite_sram_ws
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int BYTES   = HDATA_SIZE / 8;
    localparam int LANE_AW = $clog2(BYTES);
    localparam int WORD_AW = $clog2(DEPTH);
    localparam int SPAN_AW = LANE_AW + WORD_AW;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t state;
    logic [3:0] cnt;
    logic accept, legal, done, rd_done;
    logic [7:0] be_full;
    logic dp_valid, dp_write;
    logic [WORD_AW-1:0] dp_addr;
    logic [BYTES-1:0] dp_be;
    logic [HDATA_SIZE-1:0] mem_rdata, rdata_q;
    logic unused_ok;

    assign accept = HSEL & HREADY & HTRANS[1];
    assign legal = (HSIZE <= 3'(LANE_AW))
                && ((HADDR[2:0] & 3'((4'd1 << HSIZE[1:0]) - 4'd1)) == 3'd0)
                && ((HADDR >> SPAN_AW) == '0);
    assign be_full = byte_enable(HSIZE[1:0], HADDR[2:0] & 3'(BYTES - 1));
    assign done = dp_valid & HREADYOUT;
    assign rd_done = done & ~dp_write;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0], be_full};

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
        end else if (state == ST_ERR1) begin
            state     <= ST_ERR2;
            HREADYOUT <= 1'b1;
        end else if (state == ST_WAIT && cnt != 4'd0) begin
            cnt       <= cnt - 4'd1;
            HREADYOUT <= (cnt == 4'd1);
        end else if (accept && !legal) begin
            state     <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
        end else if (accept && WS != 4'd0) begin
            state     <= ST_WAIT;
            cnt       <= WS;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_OKAY;
        end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
        end

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_be    <= '0;
            rdata_q  <= '0;
        end else begin
            if (rd_done) rdata_q <= mem_rdata;
            if (HREADYOUT) begin
                dp_valid <= accept & legal;
                dp_write <= HWRITE;
                dp_addr  <= HADDR[SPAN_AW-1:LANE_AW];
                dp_be    <= be_full[BYTES-1:0];
            end
        end

    // The array is read in the data phase, after any preceding write has committed on the
    // edge that started it, so a read overlapping a same-word write sees the merged data.
    assign HRDATA = rd_done ? mem_rdata : (HRESP ? '0 : rdata_q);

    sram_1rw_be #(.DEPTH(DEPTH), .WIDTH(HDATA_SIZE)) u_sram (
        .clk  (HCLK),
        .we   (done & dp_write),
        .be   (dp_be),
        .addr (dp_addr),
        .wdata(HWDATA),
        .rdata(mem_rdata)
    );
endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// tb_ahb3lite_sram_ws: directed AHB3-Lite stimulus against a zero-wait and a two-wait slave,
// with a reference memory model feeding a scoreboard checked at each data-phase completion.
module tb_ahb3lite_sram_ws;
    typedef struct {
        string       tag;
        logic        wr;
        logic        resp;
        int          len;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic hsel0, hsel1, hwrite, cur;
    logic [31:0] haddr, hwdata, wd_next, hrdata0, hrdata1;
    logic [2:0] hsize, hburst;
    logic [3:0] hprot;
    logic [1:0] htrans;
    logic hro0, hro1, hresp0, hresp1;
    logic m_sel, m_ready, m_resp;
    logic [31:0] m_rdata;
    logic [31:0] mdl [int];
    exp_t q[$];
    exp_t e;
    int checks = 0, failures = 0;
    logic active = 1'b0;
    int cyc = 0, resp_bad = 0;

    always #5 clk = ~clk;

    ahb3lite_sram_ws #(.WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HREADY(hro0), .HREADYOUT(hro0), .HRESP(hresp0)
    );

    ahb3lite_sram_ws #(.WAIT_STATES(2)) u_ws2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel1), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata1), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HREADY(hro1), .HREADYOUT(hro1), .HRESP(hresp1)
    );

    assign m_sel   = cur ? hsel1 : hsel0;
    assign m_ready = cur ? hro1 : hro0;
    assign m_resp  = cur ? hresp1 : hresp0;
    assign m_rdata = cur ? hrdata1 : hrdata0;

    // Data-phase monitor: counts cycles until HREADYOUT and checks against the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            active = 1'b0;
            cyc = 0;
            resp_bad = 0;
        end else begin
            if (active) begin
                cyc++;
                if (q.size() > 0 && m_resp !== q[0].resp) resp_bad++;
                if (m_ready === 1'b1) begin
                    checks++;
                    assert (q.size() > 0) else begin
                        failures++;
                        $error("FAIL sb_empty: got unexpected data phase want queued transfer");
                    end
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        checks++;
                        assert (cyc === e.len) else begin
                            failures++;
                            $error("FAIL %s len: got %0d want %0d", e.tag, cyc, e.len);
                        end
                        checks++;
                        assert (resp_bad === 0) else begin
                            failures++;
                            $error("FAIL %s hresp: got %0d bad cycles want 0 (want resp %0b)", e.tag, resp_bad, e.resp);
                        end
                        if (!e.wr || e.resp) begin
                            checks++;
                            assert (m_rdata === e.rdata) else begin
                                failures++;
                                $error("FAIL %s hrdata: got %h want %h", e.tag, m_rdata, e.rdata);
                            end
                        end
                    end
                    active = 1'b0;
                    cyc = 0;
                    resp_bad = 0;
                end
            end
            if (m_sel && m_ready && htrans[1]) active = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (m_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 40) else begin
            failures++;
            $error("FAIL %s timeout: got %0d stalled cycles want <40", tag, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input string tag, input logic wr, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] trans);
        exp_t x;
        int key, off, nb;
        logic [31:0] w;
        logic ok;
        ok  = (size <= 3'd2) && ((addr & ((32'd1 << size) - 32'd1)) == 32'd0) && (addr < 32'h400);
        key = int'(cur) * 256 + int'(addr[9:2]);
        off = int'(addr[1:0]);
        nb  = 1 << size;
        x.tag = tag;
        x.wr = wr;
        x.resp = !ok;
        x.len = !ok ? 2 : (cur ? 3 : 1);
        x.rdata = '0;
        w = mdl.exists(key) ? mdl[key] : 32'h0;
        if (ok && wr) begin
            for (int b = 0; b < 4; b++)
                if (b >= off && b < off + nb) w[b*8 +: 8] = wdata[b*8 +: 8];
            mdl[key] = w;
        end
        if (ok && !wr) x.rdata = w;
        q.push_back(x);
        hsel0 = !cur;
        hsel1 = cur;
        haddr = addr;
        hwrite = wr;
        hsize = size;
        htrans = trans;
        hwdata = wd_next;
        wait_ready(tag);
        wd_next = wdata;
    endtask

    task automatic idle(input int n);
        hsel0 = 1'b0;
        hsel1 = 1'b0;
        htrans = 2'b00;
        hwdata = wd_next;
        wait_ready("idle");
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        hsel0 = 0; hsel1 = 0; haddr = 0; hwdata = 0; wd_next = 0; hwrite = 0;
        hsize = 3'd2; hburst = 3'd0; hprot = 4'b0011; htrans = 2'b00; cur = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready_ws0", {31'd0, hro0}, 32'd1);
        chk("rst_resp_ws0", {31'd0, hresp0}, 32'd0);
        chk("rst_rdata_ws0", hrdata0, 32'd0);
        chk("rst_ready_ws2", {31'd0, hro1}, 32'd1);
        chk("rst_resp_ws2", {31'd0, hresp1}, 32'd0);
        chk("rst_rdata_ws2", hrdata1, 32'd0);

        // Reset mid-WAIT on the two-wait slave; memory must survive it.
        cur = 1;
        xfer("t1_wr", 1, 3'd2, 32'h10, 32'hDEADBEEF, 2'b10);
        idle(1);
        hsel1 = 1; haddr = 32'h10; hwrite = 0; hsize = 3'd2; htrans = 2'b10;
        @(posedge clk);
        #1;
        hsel1 = 0; htrans = 2'b00;
        chk("t1_in_wait", {31'd0, hro1}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_ready", {31'd0, hro1}, 32'd1);
        chk("t1_async_resp", {31'd0, hresp1}, 32'd0);
        chk("t1_async_rdata", hrdata1, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer("t1_rd", 0, 3'd2, 32'h10, 32'h0, 2'b10);
        idle(1);

        xfer("t2_wr", 1, 3'd2, 32'h40, 32'hA5A5A5A5, 2'b10);
        xfer("t2_rd", 0, 3'd2, 32'h40, 32'h0, 2'b10);
        idle(1);

        xfer("t5_wr0", 1, 3'd2, 32'h0, 32'hCAFEF00D, 2'b10);
        xfer("t5_wr_top", 1, 3'd2, 32'h3FC, 32'h0BADF00D, 2'b10);
        xfer("t5_wr_oor", 1, 3'd2, 32'h400, 32'hBAD0BAD0, 2'b10);
        xfer("t5_rd_oor", 0, 3'd2, 32'h400, 32'h0, 2'b10);
        xfer("t5_wr_misal", 1, 3'd1, 32'h3, 32'hFFFFFFFF, 2'b10);
        xfer("t5_rd_dword", 0, 3'd3, 32'h8, 32'h0, 2'b10);
        xfer("t5_rd0", 0, 3'd2, 32'h0, 32'h0, 2'b10);
        xfer("t5_rd_top", 0, 3'd2, 32'h3FC, 32'h0, 2'b10);
        idle(1);

        cur = 0;
        xfer("t3_wr0", 1, 3'd2, 32'h8, 32'h00000000, 2'b10);
        xfer("t3_wrb", 1, 3'd0, 32'h9, 32'hFFFF11FF, 2'b10);
        xfer("t3_wrh", 1, 3'd1, 32'hA, 32'h3344FFFF, 2'b10);
        xfer("t3_rd", 0, 3'd2, 32'h8, 32'h0, 2'b10);
        idle(1);
        chk("t3_rdata_const", hrdata0, 32'h33441100);

        xfer("t4_wr", 1, 3'd2, 32'h20, 32'h12345678, 2'b10);
        xfer("t4_rd", 0, 3'd2, 32'h20, 32'h0, 2'b10);
        idle(1);
        chk("t4_rdata_const", hrdata0, 32'h12345678);

        xfer("t5_ws0_rd_oor", 0, 3'd2, 32'h400, 32'h0, 2'b10);
        xfer("t5_ws0_rd_misal", 0, 3'd1, 32'h3, 32'h0, 2'b10);
        idle(1);

        hburst = 3'b011;
        for (int i = 0; i < 4; i++)
            xfer($sformatf("t6_wr%0d", i), 1, 3'd2, 32'h100 + 32'(i * 4), 32'(i + 1), i == 0 ? 2'b10 : 2'b11);
        for (int i = 0; i < 4; i++)
            xfer($sformatf("t6_rd%0d", i), 0, 3'd2, 32'h100 + 32'(i * 4), 32'h0, i == 0 ? 2'b10 : 2'b11);
        hburst = 3'b000;
        idle(2);

        checks++;
        assert (q.size() === 0) else begin
            failures++;
            $error("FAIL sb_drain: got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
